// File: rtl/disp_ctrl_if.sv
// disp_ctrl_if: timer-core/scan-driver bundle for the display controller.
interface disp_ctrl_if;
    logic [1:0]  MODE;
    logic [2:0]  SEL;
    logic        UPD;
    logic [31:0] TIME;
    logic        SCAN_CE;
    logic [31:0] DIG;
    logic [7:0]  E;
    logic [7:0]  DP;
    modport master (output MODE, SEL, UPD, TIME, input SCAN_CE, DIG, E, DP);
    modport slave (input MODE, SEL, UPD, TIME, output SCAN_CE, DIG, E, DP);
endinterface

// File: rtl/disp_ctrl.sv
// disp_ctrl: 8-digit 7-seg display controller with scan prescaler,
// leading-zero blanking, set-mode digit blink and alarm blink.
module disp_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_HALF = 250
) (
    input logic        CLK,
    input logic        CLR,
    disp_ctrl_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [7:0] DP_BASE = 8'b0101_0100;
    typedef enum logic [1:0] {OFF, SET, RUN, ALARM} state_t;
    state_t        st;
    logic [PW-1:0] pre;
    logic [BW-1:0] bcnt;
    logic          ph;
    logic [31:0]   t;
    logic [7:0]    blank;
    logic [7:0]    e_next;
    // digit i is blanked when it and every higher digit are zero
    always_comb begin
        blank = '0;
        for (int i = 3; i < 8; i++) blank[i] = (t >> (4 * i)) == 32'd0;
    end
    always_comb begin
        e_next = st == SET ? (ph ? 8'h00 : 8'b1 << bus.SEL)
               : (st == RUN || (st == ALARM && ph)) ? blank : 8'hFF;
    end
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            pre         <= '0;
            bcnt        <= '0;
            ph          <= 1'b1;
            st          <= OFF;
            t           <= '0;
            bus.SCAN_CE <= 1'b0;
            bus.DIG     <= '0;
            bus.E       <= 8'hFF;
            bus.DP      <= '0;
        end else begin
            pre         <= pre == PW'(SCAN_DIV - 1) ? '0 : pre + PW'(1);
            bus.SCAN_CE <= pre == PW'(SCAN_DIV - 1);
            st          <= state_t'(bus.MODE);
            if (st != state_t'(bus.MODE)) begin
                bcnt <= '0;
                ph   <= 1'b1;
            end else if (bus.SCAN_CE) begin
                bcnt <= bcnt == BW'(BLINK_HALF - 1) ? '0 : bcnt + BW'(1);
                if (bcnt == BW'(BLINK_HALF - 1)) ph <= ~ph;
            end
            if (bus.UPD) t <= bus.TIME;
            bus.DIG <= t;
            bus.E   <= e_next;
            bus.DP  <= DP_BASE & ~e_next;
        end
    end
endmodule

// File: tb/tb_disp_ctrl.sv
// tb_disp_ctrl: directed plus randomized check of disp_ctrl against an
// arithmetic reference model of the display rules.
module tb_disp_ctrl;
    localparam int D = 4;
    localparam int B = 2;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    disp_ctrl_if bus();
    disp_ctrl #(.SCAN_DIV(D), .BLINK_HALF(B)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));
    always #5 CLK = ~CLK;
    int n_cmp = 0;
    int n_bad = 0;
    int k_edge = 0;
    int restart = 0;
    logic [1:0]  m_st = 2'd0;
    logic [31:0] m_t = '0;
    logic        x_sce;
    logic [31:0] x_dig;
    logic [7:0]  x_e;
    logic [7:0]  x_dp;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask
    // visible phase after edge x, given the last restart edge r
    function automatic bit ph_at(input int x, input int r);
        int pulses;
        if (x <= r) return 1'b1;
        pulses = (x - 1) / D - ((r > 1 ? r : 1) - 1) / D;
        return ((pulses / B) % 2) == 0;
    endfunction
    function automatic logic [7:0] ref_e(input logic [1:0] s, input logic [31:0] tt,
                                         input bit p, input logic [2:0] sl);
        int top;
        logic [7:0] lz;
        top = 2;
        for (int i = 3; i < 8; i++) if (((tt >> (4 * i)) & 32'hF) != 0) top = i;
        lz = 8'hFF << (top + 1);
        case (s)
            2'd0: return 8'hFF;
            2'd1: return p ? 8'h00 : 8'(1 << sl);
            2'd2: return lz;
            default: return p ? lz : 8'hFF;
        endcase
    endfunction
    task automatic cycle();
        @(posedge CLK);
        if (!CLR) begin
            {x_sce, x_dig, x_e, x_dp} = {1'b0, 32'd0, 8'hFF, 8'h00};
            k_edge = 0;
            restart = 0;
            m_st = 2'd0;
            m_t = '0;
        end else begin
            k_edge++;
            x_sce = (k_edge % D) == 0;
            x_dig = m_t;
            x_e = ref_e(m_st, m_t, ph_at(k_edge - 1, restart), bus.SEL);
            x_dp = 8'h54 & ~x_e;
            if (bus.MODE != m_st) restart = k_edge;
            m_st = bus.MODE;
            if (bus.UPD) m_t = bus.TIME;
        end
        #1;
        chk("scan_ce", bus.SCAN_CE, x_sce);
        chk("dig", bus.DIG, x_dig);
        chk("e", bus.E, x_e);
        chk("dp", bus.DP, x_dp);
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask
    task automatic load(input logic [31:0] v);
        bus.UPD = 1'b1;
        bus.TIME = v;
        cycle();
        bus.UPD = 1'b0;
    endtask
    initial begin
        logic [31:0] tm;
        bus.MODE = 2'd0;
        bus.SEL = 3'd0;
        bus.UPD = 1'b0;
        bus.TIME = '0;
        run(3);
        CLR = 1'b1;
        run(12);
        bus.MODE = 2'd2;
        load(32'h0000_0512);
        run(2);
        chk("lz_e1", bus.E, 8'hF8);
        chk("lz_dp1", bus.DP, 8'h04);
        chk("lz_dig1", bus.DIG, 32'h0000_0512);
        load(32'h0001_3000);
        run(2);
        chk("lz_e2", bus.E, 8'hE0);
        chk("lz_dp2", bus.DP, 8'h14);
        bus.MODE = 2'd1;
        bus.SEL = 3'd3;
        load(32'h0000_0000);
        run(40);
        bus.MODE = 2'd3;
        run(40);
        bus.MODE = 2'd2;
        run(5);
        bus.MODE = 2'd1;
        bus.SEL = 3'd6;
        run(24);
        bus.MODE = 2'd3;
        load(32'h9A00_0000);
        run(10);
        CLR = 1'b0;
        cycle();
        chk("rst_e", bus.E, 8'hFF);
        chk("rst_dig", bus.DIG, 32'd0);
        CLR = 1'b1;
        run(12);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(31) == 0) bus.MODE = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) bus.SEL = 3'($urandom_range(7));
            bus.UPD = $urandom_range(3) == 0;
            tm = '0;
            for (int j = 0; j < 8; j++)
                if ($urandom_range(2) == 0) tm = tm | (32'($urandom_range(15)) << (4 * j));
            bus.TIME = tm;
            CLR = $urandom_range(199) != 0;
            cycle();
        end
        CLR = 1'b1;
        bus.UPD = 1'b0;
        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
